// File: rtl/reorder_buffer_pkg.sv
// Shared types for the Tomasulo core: reorder-buffer operation classes and default depth.
package tomasula_types;

    localparam int ROB_DEPTH = 8;

    typedef enum logic [1:0] {
        ROB_REG = 2'd0,
        ROB_LD  = 2'd1,
        ROB_ST  = 2'd2,
        ROB_BR  = 2'd3
    } rob_op_t;

endpackage

// File: rtl/reorder_buffer_commit_ctrl.sv
// In-order commit sequencer: retires the head entry and runs the memory handshake for loads/stores.
module rob_commit_ctrl
    import tomasula_types::*;
(
    input  logic    clk,
    input  logic    reset_n,
    input  logic    head_ready,
    input  rob_op_t head_op,
    input  logic    data_mem_resp,
    output logic    retire,
    output logic    regfile_load,
    output logic    ld_commit_sel,
    output logic    ld_br,
    output logic    data_read,
    output logic    data_write
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } commit_state_t;

    commit_state_t state_r;
    commit_state_t state_next_s;

    // Commit state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state and commit strobes; the memory request stays up through the response cycle
    always_comb begin
        state_next_s  = state_r;
        retire        = 1'b0;
        regfile_load  = 1'b0;
        ld_commit_sel = 1'b0;
        ld_br         = 1'b0;
        data_read     = 1'b0;
        data_write    = 1'b0;
        case (state_r)
            IDLE: begin
                if (head_ready) begin
                    case (head_op)
                        ROB_REG: begin
                            regfile_load = 1'b1;
                            retire       = 1'b1;
                        end
                        ROB_BR: begin
                            ld_br  = 1'b1;
                            retire = 1'b1;
                        end
                        ROB_LD, ROB_ST: state_next_s = MEM_WAIT;
                        default: state_next_s = IDLE;
                    endcase
                end else begin
                    state_next_s = IDLE;
                end
            end
            MEM_WAIT: begin
                data_read  = (head_op == ROB_LD);
                data_write = (head_op == ROB_ST);
                if (data_mem_resp) begin
                    retire        = 1'b1;
                    regfile_load  = (head_op == ROB_LD);
                    ld_commit_sel = (head_op == ROB_LD);
                    state_next_s  = IDLE;
                end else begin
                    state_next_s = MEM_WAIT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

endmodule

// File: rtl/reorder_buffer.sv
// Parametrised reorder buffer: in-order tag allocation, out-of-order completion,
// in-order retirement and partial flush of entries younger than a mispredicted branch.
module reorder_buffer
    import tomasula_types::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             alloc,
    input  rob_op_t          alloc_op,
    input  logic [4:0]       alloc_rd,
    input  logic [4:0]       alloc_st_src,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             full,
    output logic             empty,
    input  logic [DEPTH-1:0] set_valid,
    output logic [DEPTH-1:0] entry_valid,
    input  logic             mispredict,
    input  logic [TAG_W-1:0] mispredict_tag,
    output logic [TAG_W-1:0] head_tag,
    output logic             regfile_load,
    output logic [4:0]       commit_rd,
    output logic [4:0]       st_src_commit,
    output logic             ld_commit_sel,
    output logic             ld_br,
    output logic             data_read,
    output logic             data_write,
    input  logic             data_mem_resp
);

    logic [TAG_W-1:0] head_r;
    logic [TAG_W-1:0] tail_r;
    logic [TAG_W:0]   count_r;
    rob_op_t          op_r     [DEPTH];
    logic [4:0]       rd_r     [DEPTH];
    logic [4:0]       st_src_r [DEPTH];
    logic [DEPTH-1:0] ready_r;

    logic             alloc_ok_s;
    logic             retire_s;
    logic             head_ready_s;
    logic [TAG_W-1:0] keep_off_s;
    logic [TAG_W-1:0] off_s [DEPTH];
    logic [DEPTH-1:0] occupied_s;
    logic [DEPTH-1:0] flushed_s;
    logic [TAG_W:0]   count_next_s;
    logic [TAG_W-1:0] tail_next_s;

    assign full         = (count_r == (TAG_W+1)'(DEPTH));
    assign empty        = (count_r == {(TAG_W+1){1'b0}});
    assign alloc_tag    = tail_r;
    assign head_tag     = head_r;
    assign entry_valid  = ready_r;
    assign alloc_ok_s   = alloc && !full && !mispredict;
    assign head_ready_s = !empty && ready_r[head_r];
    assign commit_rd     = rd_r[head_r];
    assign st_src_commit = st_src_r[head_r];

    // Occupancy by distance from head; flushed entries lie beyond the branch's distance
    always_comb begin
        keep_off_s = mispredict_tag - head_r;
        for (int i = 0; i < DEPTH; i++) begin
            off_s[i]      = TAG_W'(i) - head_r;
            occupied_s[i] = ({1'b0, off_s[i]} < count_r);
            flushed_s[i]  = mispredict && occupied_s[i] && (off_s[i] > keep_off_s);
        end
    end

    // Next tail and count; a flush rebuilds count from the surviving span
    always_comb begin
        if (mispredict) begin
            tail_next_s  = mispredict_tag + TAG_W'(1);
            count_next_s = {1'b0, keep_off_s} + (TAG_W+1)'(1) - (TAG_W+1)'(retire_s);
        end else begin
            tail_next_s  = alloc_ok_s ? (tail_r + TAG_W'(1)) : tail_r;
            count_next_s = count_r + (TAG_W+1)'(alloc_ok_s) - (TAG_W+1)'(retire_s);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_r  <= {TAG_W{1'b0}};
            tail_r  <= {TAG_W{1'b0}};
            count_r <= {(TAG_W+1){1'b0}};
        end else begin
            head_r  <= retire_s ? (head_r + TAG_W'(1)) : head_r;
            tail_r  <= tail_next_s;
            count_r <= count_next_s;
        end
    end

    // Ready bits: a fresh alloc clears its entry even against a same-cycle completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_r <= {DEPTH{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_ok_s && (tail_r == TAG_W'(i))) begin
                    ready_r[i] <= 1'b0;
                end else if (flushed_s[i]) begin
                    ready_r[i] <= 1'b0;
                end else if (set_valid[i] && occupied_s[i]) begin
                    ready_r[i] <= 1'b1;
                end else begin
                    ready_r[i] <= ready_r[i];
                end
            end
        end
    end

    // Entry payload written at the tail on an accepted alloc
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                op_r[i]     <= ROB_REG;
                rd_r[i]     <= 5'd0;
                st_src_r[i] <= 5'd0;
            end
        end else if (alloc_ok_s) begin
            op_r[tail_r]     <= alloc_op;
            rd_r[tail_r]     <= alloc_rd;
            st_src_r[tail_r] <= alloc_st_src;
        end
    end

    rob_commit_ctrl u_commit (
        .clk           (clk),
        .reset_n       (reset_n),
        .head_ready    (head_ready_s),
        .head_op       (op_r[head_r]),
        .data_mem_resp (data_mem_resp),
        .retire        (retire_s),
        .regfile_load  (regfile_load),
        .ld_commit_sel (ld_commit_sel),
        .ld_br         (ld_br),
        .data_read     (data_read),
        .data_write    (data_write)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_reorder_buffer;
    import tomasula_types::*;

    localparam int DEPTH = 8;
    localparam int TAG_W = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             alloc;
    rob_op_t          alloc_op;
    logic [4:0]       alloc_rd, alloc_st_src;
    logic [TAG_W-1:0] alloc_tag, head_tag, mispredict_tag;
    logic             full, empty, mispredict;
    logic [DEPTH-1:0] set_valid, entry_valid;
    logic             regfile_load, ld_commit_sel, ld_br, data_read, data_write, data_mem_resp;
    logic [4:0]       commit_rd, st_src_commit;

    reorder_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .alloc(alloc), .alloc_op(alloc_op),
        .alloc_rd(alloc_rd), .alloc_st_src(alloc_st_src), .alloc_tag(alloc_tag),
        .full(full), .empty(empty), .set_valid(set_valid), .entry_valid(entry_valid),
        .mispredict(mispredict), .mispredict_tag(mispredict_tag), .head_tag(head_tag),
        .regfile_load(regfile_load), .commit_rd(commit_rd), .st_src_commit(st_src_commit),
        .ld_commit_sel(ld_commit_sel), .ld_br(ld_br), .data_read(data_read),
        .data_write(data_write), .data_mem_resp(data_mem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        rob_op_t    op;
        logic [4:0] rd;
        logic [4:0] st;
    } ent_t;

    ent_t             m_q[$];
    logic [DEPTH-1:0] m_ready;
    int               m_head, m_tail;
    logic             m_mem;
    int               checks = 0;
    int               errors = 0;
    logic             obs_rl, obs_sel, obs_read, obs_write;
    logic [4:0]       obs_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ready = '0;
        m_head  = 0;
        m_tail  = 0;
        m_mem   = 1'b0;
    endtask

    task automatic cycle(input logic a, input rob_op_t op, input logic [4:0] rd, input logic [4:0] st,
                         input logic [DEPTH-1:0] sv, input logic mp, input logic [TAG_W-1:0] mt,
                         input logic resp);
        logic e_rl, e_sel, e_br, e_rd, e_wr, e_ret, acc, go_mem;
        int   k;
        alloc = a; alloc_op = op; alloc_rd = rd; alloc_st_src = st;
        set_valid = sv; mispredict = mp; mispredict_tag = mt; data_mem_resp = resp;
        #1;
        e_rl = 1'b0; e_sel = 1'b0; e_br = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_ret = 1'b0;
        if (m_q.size() > 0) begin
            if (m_mem) begin
                e_rd = (m_q[0].op == ROB_LD);
                e_wr = (m_q[0].op == ROB_ST);
                if (resp) begin
                    e_ret = 1'b1;
                    e_rl  = e_rd;
                    e_sel = e_rd;
                end
            end else if (m_ready[m_q[0].tag]) begin
                if (m_q[0].op == ROB_REG) begin e_rl = 1'b1; e_ret = 1'b1; end
                if (m_q[0].op == ROB_BR)  begin e_br = 1'b1; e_ret = 1'b1; end
            end
            chk("commit_rd", commit_rd, m_q[0].rd);
            chk("st_src_commit", st_src_commit, m_q[0].st);
        end
        chk("alloc_tag", alloc_tag, m_tail);
        chk("head_tag", head_tag, m_head);
        chk("full", full, m_q.size() == DEPTH);
        chk("empty", empty, m_q.size() == 0);
        chk("entry_valid", entry_valid, m_ready);
        chk("regfile_load", regfile_load, e_rl);
        chk("ld_commit_sel", ld_commit_sel, e_sel);
        chk("ld_br", ld_br, e_br);
        chk("data_read", data_read, e_rd);
        chk("data_write", data_write, e_wr);
        obs_rl = regfile_load; obs_sel = ld_commit_sel; obs_read = data_read;
        obs_write = data_write; obs_rd = commit_rd;
        acc    = a && (m_q.size() < DEPTH) && !mp;
        go_mem = !m_mem && (m_q.size() > 0) && m_ready[m_q[0].tag] &&
                 ((m_q[0].op == ROB_LD) || (m_q[0].op == ROB_ST));
        @(posedge clk);
        foreach (m_q[i]) if (sv[m_q[i].tag]) m_ready[m_q[i].tag] = 1'b1;
        if (mp) begin
            k = 0;
            while ((k < m_q.size()) && (m_q[k].tag != int'(mt))) k++;
            while (m_q.size() > k + 1) begin
                m_ready[m_q[$].tag] = 1'b0;
                void'(m_q.pop_back());
            end
            m_tail = (int'(mt) + 1) % DEPTH;
        end
        if (e_ret) begin
            void'(m_q.pop_front());
            m_head = (m_head + 1) % DEPTH;
        end
        if (acc) begin
            m_ready[m_tail] = 1'b0;
            m_q.push_back('{tag: m_tail, op: op, rd: rd, st: st});
            m_tail = (m_tail + 1) % DEPTH;
        end
        if (go_mem) m_mem = 1'b1;
        else if (m_mem && resp) m_mem = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input logic [DEPTH-1:0] sv, input logic resp);
        cycle(1'b0, ROB_REG, 5'd0, 5'd0, sv, 1'b0, 3'd0, resp);
    endtask

    task automatic drain();
        int guard = 0;
        while (((m_q.size() != 0) || m_mem) && (guard < 64)) begin
            idle({DEPTH{1'b1}}, 1'b1);
            guard++;
        end
        chk("drain_bound", guard < 64, 1);
    endtask

    logic             r_a, r_mp;
    rob_op_t          r_op;
    logic [TAG_W-1:0] r_mt;

    initial begin
        reset_n = 1'b0; alloc = 1'b0; alloc_op = ROB_REG; alloc_rd = 5'd0; alloc_st_src = 5'd0;
        set_valid = '0; mispredict = 1'b0; mispredict_tag = 3'd0; data_mem_resp = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_alloc_tag", alloc_tag, 0);
        chk("rst_head_tag", head_tag, 0);
        chk("rst_entry_valid", entry_valid, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Fill to full, then an ignored ninth alloc
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, ROB_REG, 5'(i + 1), 5'(i), '0, 1'b0, 3'd0, 1'b0);
        chk("fill_alloc_tag", alloc_tag, 0);
        chk("fill_full", full, 1);
        cycle(1'b1, ROB_REG, 5'd31, 5'd31, '0, 1'b0, 3'd0, 1'b0);
        chk("full_ignore_tag", alloc_tag, 0);
        drain();

        // Out-of-order completion retires in tag order
        for (int i = 0; i < 3; i++) cycle(1'b1, ROB_REG, 5'(10 + i), 5'd0, '0, 1'b0, 3'd0, 1'b0);
        idle(8'b0000_0100, 1'b0);
        idle(8'b0000_0010, 1'b0);
        idle(8'b0000_0001, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle('0, 1'b0);
            chk("ooo_regfile_load", obs_rl, 1);
            chk("ooo_commit_rd", obs_rd, 10 + i);
        end

        // Load handshake: request held three cycles, then response commits
        cycle(1'b1, ROB_LD, 5'd7, 5'd0, '0, 1'b0, 3'd0, 1'b0);
        idle(8'b0000_1000, 1'b0);
        idle('0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle('0, 1'b0);
            chk("ld_data_read", obs_read, 1);
        end
        idle('0, 1'b1);
        chk("ld_resp_load", obs_rl, 1);
        chk("ld_resp_sel", obs_sel, 1);
        chk("ld_head_adv", head_tag, 4);

        // Flush younger than tag 6 with a dropped same-cycle alloc
        for (int i = 0; i < 6; i++) cycle(1'b1, ROB_BR, 5'd0, 5'd0, '0, 1'b0, 3'd0, 1'b0);
        idle(8'b1000_0011, 1'b0);
        cycle(1'b1, ROB_REG, 5'd9, 5'd9, '0, 1'b1, 3'd6, 1'b0);
        chk("flush_alloc_tag", alloc_tag, 7);
        chk("flush_ready_cleared", entry_valid & 8'b1000_0011, 0);
        drain();

        // Wrap with simultaneous alloc and REG commit
        cycle(1'b1, ROB_REG, 5'd20, 5'd0, '0, 1'b0, 3'd0, 1'b0);
        cycle(1'b1, ROB_REG, 5'd21, 5'd0, 8'b1000_0000, 1'b0, 3'd0, 1'b0);
        cycle(1'b1, ROB_REG, 5'd22, 5'd0, '0, 1'b0, 3'd0, 1'b0);
        chk("wrap_head", head_tag, 0);
        chk("wrap_tail", alloc_tag, 2);
        drain();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            r_a  = ($urandom_range(0, 9) < 6);
            r_op = rob_op_t'($urandom_range(0, 3));
            r_mp = (m_q.size() > 0) && ($urandom_range(0, 15) == 0);
            r_mt = (m_q.size() > 0) ? 3'(m_q[$urandom_range(0, m_q.size() - 1)].tag) : 3'd0;
            cycle(r_a, r_op, 5'($urandom), 5'($urandom), 8'($urandom) & 8'($urandom),
                  r_mp, r_mt, ($urandom_range(0, 2) == 0));
        end
        drain();

        // Asynchronous reset while a store waits on memory
        cycle(1'b1, ROB_ST, 5'd0, 5'd17, '0, 1'b0, 3'd0, 1'b0);
        idle({DEPTH{1'b1}}, 1'b0);
        idle('0, 1'b0);
        idle('0, 1'b0);
        chk("st_data_write", obs_write, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_dw", data_write, 0);
        chk("rst_async_empty", empty, 1);
        chk("rst_async_tag", alloc_tag, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        idle('0, 1'b0);
        chk("post_rst_empty", empty, 1);
        chk("post_rst_tag", alloc_tag, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
